// File: rtl/sgtl5000_cfg_seq.sv
// SGTL5000 power-up register writer: one I2C write (addr, reg16, val16) per table entry.
// Optional SGTL_CLK_STRETCH_EN: wait for SCL to read high before the data-valid quarter.
module sgtl5000_cfg_seq #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h0A,
    parameter int         NUM_REGS = 16,
    parameter int         IDX_W    = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_reg,
    input  logic [15:0]      tbl_val,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [39:0]      sh_q, sh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             abort_q, abort_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;

    logic active;
    logic stretch_wait;
    logic qtick;

    assign active = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef SGTL_CLK_STRETCH_EN
    // Quarter 3 of a clock-high slot only proceeds once the slave has let SCL rise.
    assign stretch_wait = ((state_q == S_BIT) || (state_q == S_ACK)) &&
                          (phase_q == 2'd3) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stretch_wait  = 1'b0;
`endif

    assign qtick = active && !stretch_wait && (div_q == DIV_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sh_q      <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh_q      <= sh_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            error_q   <= error_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        div_d     = div_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        abort_d   = abort_q;
        done_d    = done_q;
        error_d   = error_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;

        if (active && !stretch_wait) begin
            div_d = qtick ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                if (start) begin
                    state_d   = S_START;
                    phase_d   = '0;
                    div_d     = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    idx_d     = '0;
                    err_idx_d = '0;
                    abort_d   = 1'b0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end

            S_START: begin
                if (qtick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        2'd1: sda_oe_d = 1'b1;
                        2'd3: begin
                            scl_oe_d = 1'b1;
                            sh_d     = {DEV_ADDR, 1'b0, tbl_reg, tbl_val};
                            bit_d    = '0;
                            byte_d   = '0;
                            state_d  = S_BIT;
                        end
                        default: ;
                    endcase
                end
            end

            S_BIT: begin
                if (qtick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = ~sh_q[39];
                        end
                        2'd2: scl_oe_d = 1'b0;
                        2'd3: begin
                            sh_d  = {sh_q[38:0], 1'b0};
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = S_ACK;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_ACK: begin
                if (qtick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b0;
                        end
                        2'd2: scl_oe_d = 1'b0;
                        2'd3: begin
                            if (sda_in) begin
                                error_d   = 1'b1;
                                err_idx_d = idx_q;
                                abort_d   = 1'b1;
                                state_d   = S_STOP;
                            end else if (byte_q == 3'd4) begin
                                state_d = S_STOP;
                            end else begin
                                byte_d  = byte_q + 3'd1;
                                state_d = S_BIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_STOP: begin
                if (qtick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end
                        2'd1: scl_oe_d = 1'b0;
                        2'd3: begin
                            sda_oe_d = 1'b0;
                            state_d  = S_GAP;
                        end
                        default: ;
                    endcase
                end
            end

            S_GAP: begin
                if (qtick) begin
                    phase_d  = phase_q + 2'd1;
                    scl_oe_d = 1'b0;
                    sda_oe_d = 1'b0;
                    if (phase_q == 2'd3) begin
                        if (abort_q || (idx_q == IDX_LAST)) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_START;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = active;
    assign done    = done_q;
    assign error   = error_q;
    assign err_idx = err_idx_q;
    assign tbl_idx = idx_q;
    assign scl_oe  = scl_oe_q;
    assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_sgtl5000_cfg_seq.sv
// Directed bench: two sequencers on one modelled open-drain bus with an I2C slave decoder.
module tb_sgtl5000_cfg_seq;

    localparam int STRETCH_DLY =
`ifdef SGTL_CLK_STRETCH_EN
        37;
`else
        0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       busy0, done0, error0, busy1, done1, error1;
    logic [7:0] err_idx0, tbl_idx0, err_idx1, tbl_idx1;
    logic [15:0] tbl_reg0, tbl_val0, tbl_reg1, tbl_val1;
    logic       scl_oe0, sda_oe0, scl_oe1, sda_oe1;
    logic       scl_line, sda_line;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   hold_cnt = 0;
    logic slave_low = 1'b0;
    int   starts = 0, stops = 0;
    int   bitcnt = 0, bif = 0;
    logic [7:0] shreg = '0;
    logic [7:0] rx[$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0;

    int   nack_frame = -1, nack_byte = -1;
    logic stretch_go = 1'b0;
    int   stretch_frame = -1;

    logic [7:0] exp_bytes [10] = '{8'h14, 8'h00, 8'h02, 8'h00, 8'h60,
                                   8'h14, 8'h00, 8'h30, 8'h42, 8'h60};

    always #5 clk = ~clk;

    function automatic logic [31:0] tbl(input logic [7:0] i);
        case (i)
            8'd0:    return 32'h0002_0060;
            8'd1:    return 32'h0030_4260;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign {tbl_reg0, tbl_val0} = tbl(tbl_idx0);
    assign {tbl_reg1, tbl_val1} = tbl(tbl_idx1);
    assign scl_line = !(scl_oe0 | scl_oe1) && (hold_cnt == 0);
    assign sda_line = !(sda_oe0 | sda_oe1) && !slave_low;

    sgtl5000_cfg_seq #(.CLK_DIV(4), .DEV_ADDR(7'h0A), .NUM_REGS(2), .IDX_W(8)) u_dut0 (
        .Clk(clk), .Reset(rst), .start(start0), .busy(busy0), .done(done0),
        .error(error0), .err_idx(err_idx0), .tbl_idx(tbl_idx0),
        .tbl_reg(tbl_reg0), .tbl_val(tbl_val0), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe0), .sda_oe(sda_oe0)
    );

    sgtl5000_cfg_seq #(.CLK_DIV(4), .DEV_ADDR(7'h0A), .NUM_REGS(1), .IDX_W(8)) u_dut1 (
        .Clk(clk), .Reset(rst), .start(start1), .busy(busy1), .done(done1),
        .error(error1), .err_idx(err_idx1), .tbl_idx(tbl_idx1),
        .tbl_reg(tbl_reg1), .tbl_val(tbl_val1), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe1), .sda_oe(sda_oe1)
    );

    // Slave decodes the master's own SCL intent, so a stretch never hides a bit from it.
    always @(negedge clk) begin
        logic cs, cd, oe_now;
        if (hold_cnt > 0) hold_cnt--;
        oe_now = scl_oe0 | scl_oe1;
        if (rst) begin
            bitcnt = 0; bif = 0; slave_low = 1'b0; hold_cnt = 0;
            prev_scl = 1'b1; prev_sda = 1'b1; prev_oe = 1'b0;
        end else begin
            if (stretch_go && prev_oe && !oe_now && bitcnt == 8 &&
                starts == stretch_frame && bif == 0)
                hold_cnt = 37;
            cs = !oe_now;
            cd = !(sda_oe0 | sda_oe1) && !slave_low;
            if (cs && prev_scl && prev_sda && !cd) begin
                starts++; bitcnt = 0; bif = 0; slave_low = 1'b0;
            end else if (cs && prev_scl && !prev_sda && cd) begin
                stops++;
            end else if (cs && !prev_scl) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], cd};
                    bitcnt++;
                    if (bitcnt == 8) rx.push_back(shreg);
                end else begin
                    bitcnt = 0; bif++;
                end
            end else if (!cs && prev_scl) begin
                slave_low = (bitcnt == 8) && !(starts == nack_frame && bif == nack_byte);
            end
            prev_scl = cs; prev_sda = cd; prev_oe = oe_now;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait0(input int repulse_at, output int cyc);
        cyc = 0;
        while (busy0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start0 = (cyc == repulse_at);
        end
        start0 = 1'b0;
    endtask

    task automatic wait_oe(input logic val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (scl_oe0 === val) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic check_bytes(input string name, input int base, input int n, input int off);
        n_checks++;
        if (rx.size() !== base + n) begin
            n_fail++;
            $display("FAIL %s byte count: got %0d required %0d", name, rx.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (rx[base + i] !== exp_bytes[off + i]) begin
                    n_fail++;
                    $display("FAIL %s byte %0d: got %h required %h", name, i, rx[base + i], exp_bytes[off + i]);
                end
            end
        end
    endtask

    task automatic check_dur(input string name, input int cyc, input int req);
        n_checks++;
        if (cyc < req - 2 || cyc > req + 2) begin
            n_fail++;
            $display("FAIL %s busy cycles: got %0d required %0d", name, cyc, req);
        end
    endtask

    task automatic check_end(input string name, input logic d, input logic e, input logic [7:0] ei,
                             input logic [7:0] ti, input int ds, input int dp, input int es, input int ep);
        n_checks++;
        if ({busy0, done0, error0, err_idx0, tbl_idx0} !== {1'b0, d, e, ei, ti}) begin
            n_fail++;
            $display("FAIL %s status busy/done/error/err_idx/tbl_idx: got %b/%b/%b/%0d/%0d required 0/%b/%b/%0d/%0d",
                     name, busy0, done0, error0, err_idx0, tbl_idx0, d, e, ei, ti);
        end
        n_checks++;
        if (ds !== es || dp !== ep) begin
            n_fail++;
            $display("FAIL %s start/stop count: got %0d/%0d required %0d/%0d", name, ds, dp, es, ep);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy0, done0, error0, err_idx0, tbl_idx0, scl_oe0, sda_oe0} !== '0) begin
            n_fail++;
            $display("FAIL reset dut0 outputs: got %b required 0",
                     {busy0, done0, error0, err_idx0, tbl_idx0, scl_oe0, sda_oe0});
        end
        n_checks++;
        if ({busy1, done1, error1, err_idx1, tbl_idx1, scl_oe1, sda_oe1} !== '0) begin
            n_fail++;
            $display("FAIL reset dut1 outputs: got %b required 0",
                     {busy1, done1, error1, err_idx1, tbl_idx1, scl_oe1, sda_oe1});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_entries();
        int base = rx.size(), s0 = starts, p0 = stops, cyc;
        pulse0();
        wait0(-1, cyc);
        check_dur("two_entries", cyc, 2 * 192 * 4);
        check_bytes("two_entries", base, 10, 0);
        check_end("two_entries", 1'b1, 1'b0, 8'd0, 8'd1, starts - s0, stops - p0, 2, 2);
    endtask

    task automatic test_nack_entry1();
        int base = rx.size(), s0 = starts, p0 = stops, cyc;
        nack_frame = starts + 2; nack_byte = 2;
        pulse0();
        wait0(-1, cyc);
        nack_frame = -1; nack_byte = -1;
        check_dur("nack_entry1", cyc, (192 + 4 + 3 * 36 + 8) * 4);
        check_bytes("nack_entry1", base, 8, 0);
        check_end("nack_entry1", 1'b1, 1'b1, 8'd1, 8'd1, starts - s0, stops - p0, 2, 2);
    endtask

    task automatic test_restart_after_done();
        int base = rx.size(), cyc;
        pulse0();
        n_checks++;
        if ({busy0, done0, error0, err_idx0, tbl_idx0} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL restart clear busy/done/error/err_idx/tbl_idx: got %b/%b/%b/%0d/%0d required 1/0/0/0/0",
                     busy0, done0, error0, err_idx0, tbl_idx0);
        end
        wait0(-1, cyc);
        check_dur("restart", cyc, 2 * 192 * 4);
        check_bytes("restart", base, 10, 0);
    endtask

    task automatic test_nack_first();
        int base = rx.size(), s0 = starts, p0 = stops, cyc;
        nack_frame = starts + 1; nack_byte = 0;
        pulse0();
        wait0(-1, cyc);
        nack_frame = -1; nack_byte = -1;
        check_dur("nack_first", cyc, 48 * 4);
        check_bytes("nack_first", base, 1, 0);
        check_end("nack_first", 1'b1, 1'b1, 8'd0, 8'd0, starts - s0, stops - p0, 1, 1);
    endtask

    task automatic test_start_while_busy();
        int base = rx.size(), s0 = starts, p0 = stops, cyc;
        pulse0();
        wait0(300, cyc);
        check_dur("start_while_busy", cyc, 2 * 192 * 4);
        check_bytes("start_while_busy", base, 10, 0);
        check_end("start_while_busy", 1'b1, 1'b0, 8'd0, 8'd1, starts - s0, stops - p0, 2, 2);
    endtask

    task automatic test_reset_mid();
        int base = rx.size(), s0, p0, cyc;
        bit ok1, ok2, ok3;
        pulse0();
        for (int i = 0; i < 2000 && rx.size() < base + 1; i++) @(negedge clk);
        wait_oe(1'b1, ok1);
        wait_oe(1'b0, ok2);
        wait_oe(1'b1, ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || {scl_oe0, sda_oe0} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid reach byte2: got scl_oe/sda_oe %b%b found %0d required 11 found 1",
                     scl_oe0, sda_oe0, ok1 && ok2 && ok3);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy0, done0, error0, err_idx0, tbl_idx0, scl_oe0, sda_oe0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid async outputs: got %b required 0",
                     {busy0, done0, error0, err_idx0, tbl_idx0, scl_oe0, sda_oe0});
        end
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        base = rx.size(); s0 = starts; p0 = stops;
        pulse0();
        wait0(-1, cyc);
        check_dur("after_reset", cyc, 2 * 192 * 4);
        check_bytes("after_reset", base, 10, 0);
        check_end("after_reset", 1'b1, 1'b0, 8'd0, 8'd1, starts - s0, stops - p0, 2, 2);
    endtask

    task automatic test_stretch();
        int base = rx.size(), cyc;
        stretch_frame = starts + 1; stretch_go = 1'b1;
        pulse0();
        wait0(-1, cyc);
        stretch_go = 1'b0;
        check_dur("stretch", cyc, 2 * 192 * 4 + STRETCH_DLY);
        check_bytes("stretch", base, 10, 0);
        n_checks++;
        if ({done0, error0} !== 2'b10) begin
            n_fail++;
            $display("FAIL stretch done/error: got %b%b required 10", done0, error0);
        end
    endtask

    task automatic test_single_entry();
        int base = rx.size(), s0 = starts, p0 = stops, cyc = 0;
        bit idx_bad = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        while (busy1 && cyc < 5000) begin
            if (tbl_idx1 !== 8'd0) idx_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc < 768 - 2 || cyc > 768 + 2) begin
            n_fail++;
            $display("FAIL single busy cycles: got %0d required 768", cyc);
        end
        check_bytes("single", base, 5, 0);
        n_checks++;
        if (idx_bad || {done1, error1, err_idx1, tbl_idx1} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL single idx_moved/done/error/err_idx/tbl_idx: got %b/%b/%b/%0d/%0d required 0/1/0/0/0",
                     idx_bad, done1, error1, err_idx1, tbl_idx1);
        end
        n_checks++;
        if (starts - s0 !== 1 || stops - p0 !== 1) begin
            n_fail++;
            $display("FAIL single start/stop count: got %0d/%0d required 1/1", starts - s0, stops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_two_entries();
        test_nack_entry1();
        test_restart_after_done();
        test_nack_first();
        test_start_while_busy();
        test_reset_mid();
        test_stretch();
        test_single_entry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
